mul8_err_sweep: RTL

Exhaustive operand-sweep and error-accumulation engine for the 8x8 approximate multipliers. It sits on both sides of a multiplier under test. Upstream, it drives every (a, b) operand pair in sequence. Downstream, it consumes the 16-bit product and accumulates error metrics against the exact product: error count, sum of error distance, maximum error distance and the operands that produced it. It is used for on-FPGA characterisation of each multiplier configuration without host involvement.

---
 rtl/mul8_err_sweep_if.sv | 47 ++++
 rtl/mul8_err_sweep.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mul8_err_sweep_if.sv
// mul8_err_sweep_if
// Bundles the operand/product path to the multiplier under test together with
// the control handshake and the accumulated error metrics of the sweep engine.
//   start          : request a new sweep
//   busy, done     : engine status (busy in RUN/DRAIN, done held in DONE)
//   op_a, op_b     : operands driven to the multiplier under test
//   prod_in        : product returned combinationally by the multiplier
//   err_cnt        : number of pairs with a non-zero error distance
//   sum_ed         : sum of error distances
//   max_ed         : largest error distance, max_a/max_b its first operands
//   sum_sq         : sum of squared error distances (only with ERR_SQ_EN)
// Modports: master = sweep engine, slave = host/multiplier side.
// Optional feature macro: ERR_SQ_EN.
interface mul8_err_sweep_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [15:0] prod_in;
    logic [16:0] err_cnt;
    logic [31:0] sum_ed;
    logic [15:0] max_ed;
    logic [7:0]  max_a;
    logic [7:0]  max_b;
`ifdef ERR_SQ_EN
    logic [47:0] sum_sq;

    modport master (
        input  start, prod_in,
        output busy, done, op_a, op_b, err_cnt, sum_ed, max_ed, max_a, max_b, sum_sq
    );
    modport slave (
        output start, prod_in,
        input  busy, done, op_a, op_b, err_cnt, sum_ed, max_ed, max_a, max_b, sum_sq
    );
`else
    modport master (
        input  start, prod_in,
        output busy, done, op_a, op_b, err_cnt, sum_ed, max_ed, max_a, max_b
    );
    modport slave (
        output start, prod_in,
        input  busy, done, op_a, op_b, err_cnt, sum_ed, max_ed, max_a, max_b
    );
`endif
endinterface

// File: rtl/mul8_err_sweep.sv
// mul8_err_sweep
// Exhaustive operand sweep and error accumulator for 8x8 approximate multipliers.
// Drives every {op_a, op_b} index from 0 to SWEEP_LAST (op_b fastest), measures
// |prod_in - op_a*op_b| one cycle later and accumulates the error metrics.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : mul8_err_sweep_if.master (start/busy/done, operands, product, metrics)
// Parameter: SWEEP_LAST - last sweep index, smaller values give partial sweeps.
// Optional feature macro: ERR_SQ_EN adds the squared-error accumulator sum_sq.
module mul8_err_sweep #(
    parameter logic [15:0] SWEEP_LAST = 16'hFFFF
) (
    input logic             clk,
    input logic             rst,
    mul8_err_sweep_if.master bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e      state_q, state_d;
    logic        launch;

    logic [15:0] idx_q;
    logic        v_q;
    logic [15:0] ed_q;
    logic [7:0]  ed_a_q, ed_b_q;
    logic [16:0] err_cnt_q;
    logic [31:0] sum_ed_q;
    logic [15:0] max_ed_q;
    logic [7:0]  max_a_q, max_b_q;

    logic [15:0] exact;
    logic [16:0] diff;
    logic [15:0] ed;

    // Next-state logic; launch marks the edge that clears the datapath.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StRun;
                    launch  = 1'b1;
                end
            end
            StRun:   if (idx_q == SWEEP_LAST) state_d = StDrain;
            StDrain: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Stage 1: error distance of the pair currently on op_a/op_b.
    always_comb begin
        exact = {8'h00, bus.op_a} * {8'h00, bus.op_b};
        diff  = {1'b0, bus.prod_in} - {1'b0, exact};
        // |diff| <= 65535, so the low 16 bits of the negation are exact.
        ed    = diff[16] ? (~diff[15:0] + 16'd1) : diff[15:0];
    end

`ifdef ERR_SQ_EN
    logic [47:0] sum_sq_q;
    logic [31:0] sq;
    assign sq = {16'h0000, ed_q} * {16'h0000, ed_q};
`endif

    always_ff @(posedge clk) begin
        if (rst || launch) begin
            idx_q     <= '0;
            v_q       <= 1'b0;
            ed_q      <= '0;
            ed_a_q    <= '0;
            ed_b_q    <= '0;
            err_cnt_q <= '0;
            sum_ed_q  <= '0;
            max_ed_q  <= '0;
            max_a_q   <= '0;
            max_b_q   <= '0;
`ifdef ERR_SQ_EN
            sum_sq_q  <= '0;
`endif
        end else begin
            v_q    <= (state_q == StRun);
            ed_q   <= ed;
            ed_a_q <= bus.op_a;
            ed_b_q <= bus.op_b;
            // idx holds on the last pair so the operands stay put through DONE.
            if (state_q == StRun && idx_q != SWEEP_LAST) idx_q <= idx_q + 16'd1;
            // Stage 2: accumulate the registered error distance.
            if (v_q) begin
                err_cnt_q <= err_cnt_q + {16'h0000, (ed_q != 16'h0000)};
                sum_ed_q  <= sum_ed_q + {16'h0000, ed_q};
`ifdef ERR_SQ_EN
                sum_sq_q  <= sum_sq_q + {16'h0000, sq};
`endif
                // Strictly greater: the first pair reaching the maximum wins.
                if (ed_q > max_ed_q) begin
                    max_ed_q <= ed_q;
                    max_a_q  <= ed_a_q;
                    max_b_q  <= ed_b_q;
                end
            end
        end
    end

    assign bus.op_a    = idx_q[15:8];
    assign bus.op_b    = idx_q[7:0];
    assign bus.busy    = (state_q == StRun) || (state_q == StDrain);
    assign bus.done    = (state_q == StDone);
    assign bus.err_cnt = err_cnt_q;
    assign bus.sum_ed  = sum_ed_q;
    assign bus.max_ed  = max_ed_q;
    assign bus.max_a   = max_a_q;
    assign bus.max_b   = max_b_q;
`ifdef ERR_SQ_EN
    assign bus.sum_sq  = sum_sq_q;
`endif

endmodule
